// File: rtl/sr_register_bank.sv
// Bank of WIDTH independent SR latches. Each s/r input is qualified by a
// FILT-cycle consecutive-high filter. Conflict flags are sticky, changed flags pulse.
module sr_register_bank #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned FILT  = 2,
  parameter int unsigned MODE  = 0,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] conflict,
  output logic [WIDTH-1:0] changed
);

  localparam int unsigned      CW   = $clog2(FILT + 1);
  localparam logic [CW-1:0]    CMAX = CW'(FILT);
  localparam logic [WIDTH-1:0] QRST = (INIT != 0) ? '1 : '0;

  logic [CW-1:0]    cnt_s      [WIDTH];
  logic [CW-1:0]    cnt_r      [WIDTH];
  logic [CW-1:0]    cnt_s_next [WIDTH];
  logic [CW-1:0]    cnt_r_next [WIDTH];
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict_next;
  logic [WIDTH-1:0] changed_next;

  // Filter counters, qualification decode and per-channel next state
  always_comb begin
    s_q           = '0;
    r_q           = '0;
    q_next        = q;
    conflict_next = conflict;
    changed_next  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_s_next[i] = '0;
      cnt_r_next[i] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      s_q[i] = (cnt_s[i] == CMAX);
      r_q[i] = (cnt_r[i] == CMAX);
      if (s[i]) cnt_s_next[i] = s_q[i] ? CMAX : cnt_s[i] + CW'(1);
      if (r[i]) cnt_r_next[i] = r_q[i] ? CMAX : cnt_r[i] + CW'(1);
      if (s_q[i] && !r_q[i]) begin
        q_next[i] = 1'b1;
      end else if (r_q[i] && !s_q[i]) begin
        q_next[i] = 1'b0;
      end else if (s_q[i] && r_q[i]) begin
        case (MODE)
          1:       q_next[i] = 1'b1;
          2:       q_next[i] = 1'b0;
          3:       q_next[i] = ~q[i];
          default: q_next[i] = q[i];
        endcase
      end
    end
    // A fresh conflict beats a simultaneous clear
    conflict_next = (conflict & ~{WIDTH{clr_conflict}}) | (s_q & r_q);
    changed_next  = q_next ^ q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= QRST;
      qb       <= ~QRST;
      conflict <= '0;
      changed  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_s[i] <= '0;
        cnt_r[i] <= '0;
      end
    end else begin
      q        <= q_next;
      qb       <= ~q_next;
      conflict <= conflict_next;
      changed  <= changed_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_s[i] <= cnt_s_next[i];
        cnt_r[i] <= cnt_r_next[i];
      end
    end
  end

endmodule

// File: doc/sr_register_bank.md
SR_REGISTER_BANK -- requirements
Module: sr_register_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of independent SR channels (>=1).
REQ-002 Parameter FILT, default 2: consecutive sampled-high cycles before s/r takes effect (>=1).
REQ-003 Parameter MODE, default 0: action when both s and r are qualified; 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
REQ-004 Parameter INIT, default 0: reset value of every q bit (0 or 1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 s  input  WIDTH  per-channel set request.
REQ-008 r  input  WIDTH  per-channel reset request.
REQ-009 clr_conflict  input  1  clears all conflict flags.
REQ-010 q  output  WIDTH  registered channel state.
REQ-011 qb  output  WIDTH  complement of q.
REQ-012 conflict  output  WIDTH  sticky flag: both s and r were qualified in the same cycle.
REQ-013 changed  output  WIDTH  one-cycle pulse: q bit changed on the preceding edge.

Function
REQ-014 Each channel SHALL keep independent saturating counters cnt_s and cnt_r of width clog2(FILT+1).
REQ-015 At each edge, a counter SHALL increment (saturating at FILT) if its input is 1, and SHALL clear to 0 if the input is 0.
REQ-016 Qualified signals SHALL be s_q = (cnt_s==FILT) and r_q = (cnt_r==FILT), decoded from registered counters.
REQ-017 At each edge, q[i] SHALL be set to 1 if s_q & ~r_q, and set to 0 if r_q & ~s_q.
REQ-018 If neither s_q nor r_q is asserted, q[i] SHALL hold.
REQ-019 If s_q & r_q, q[i] SHALL follow MODE: hold, set to 1, set to 0, or invert.
REQ-020 In MODE 3, q[i] SHALL invert on every edge while both inputs stay qualified.
REQ-021 Latency from the first edge sampling s=1 (or r=1) continuously to the q update SHALL be FILT+1 edges.
REQ-022 A pulse shorter than FILT sampled cycles SHALL have no effect on q, changed or conflict.
REQ-023 qb SHALL equal ~q at all times; the invalid q=qb=0 state SHALL NOT occur.
REQ-024 conflict[i] SHALL be set on the edge following any cycle with s_q[i] & r_q[i].
REQ-025 conflict[i] SHALL then hold until cleared.
REQ-026 When clr_conflict=1, all conflict bits SHALL clear on that edge.
REQ-027 A new conflict in the same cycle as clr_conflict SHALL win, leaving that bit set.
REQ-028 changed[i] SHALL be 1 for exactly the cycle after an edge on which q[i] changed value, and 0 otherwise.
REQ-029 In MODE 3, changed[i] SHALL stay 1 continuously while q[i] is toggling.
REQ-030 Channels SHALL NOT interact; every channel SHALL behave identically under identical stimulus.

Reset
REQ-031 On an edge with rst=1, q SHALL become {WIDTH{INIT}}, qb its complement, and all counters, conflict and changed SHALL become 0.
REQ-032 rst SHALL take priority over s, r and clr_conflict.
REQ-033 A request that was partly counted when reset occurs SHALL restart its qualification from zero.

Verification (WIDTH=4, FILT=2, INIT=0 unless noted)
REQ-034 Set: after rst, hold s[0]=1 from edge 1 -> q[0]=1, qb[0]=0 after edge 3; changed[0]=1 for one cycle only; other bits unchanged.
REQ-035 Glitch: s[1]=1 for one sampled cycle, or r[0]=1 for one cycle while q[0]=1 -> q unchanged, changed=0, conflict=0.
REQ-036 Conflict modes: q[2]=1, then s[2]=r[2]=1 held for 4 cycles, run for each MODE instance:
- MODE 0: q[2] holds 1.
- MODE 1: q[2]=1.
- MODE 2: q[2]=0 after edge 3.
- MODE 3: q[2] toggles every edge from edge 3.
- All modes: conflict[2]=1 persists after inputs drop.
REQ-037 Clear: pulse clr_conflict with no active conflict -> conflict=0 next edge. Pulse it during an ongoing conflict on ch3 -> conflict[3] stays 1.
REQ-038 Reset mid-operation: s[1] counted once, rst for 1 cycle, s[1] stays high -> all outputs return to reset values; q[1]=1 only 3 edges after rst deasserts.
REQ-039 Parallel: channels 0-3 driven with set, reset, conflict and idle simultaneously -> each matches its solo result; parameter sweep FILT=1 and INIT=1 checks latency 2 and reset q=4'b1111.
